// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer: FSM states, widths, LFSR helper.
package reaction_pkg;

    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned MS_W       = 14;
    localparam int unsigned LFSR_W     = 16;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RESULT  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // One shift of the LFSR: feedback is the XOR of the tapped bits, shifted in at bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Four-digit cascaded decimal counter with synchronous clear and increment enable.
// Ports: CLK, RST_N (sync active-low), clear (zero all digits), inc (add one),
//        bcd (digits, [15:12] = thousands). 9999 + 1 wraps to 0000.
module bcd_counter
    import reaction_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clear,
    input  logic             inc,
    output logic [BCD_W-1:0] bcd
);

    logic [BCD_W-1:0] bcd_nxt;

    // Ripple the carry through every digit within one cycle
    always_comb begin : next_digits
        logic carry;
        bcd_nxt = bcd;
        carry   = inc;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcd_nxt[4*i +: 4] = 4'd0;
                end else begin
                    bcd_nxt[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (clear) begin
            bcd_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bcd <= '0;
        end else begin
            bcd <= bcd_nxt;
        end
    end

endmodule

// File: rtl/reaction_measure.sv
// Reaction timer measurement core: start press, random wait, LED on, then
// counts 1 ms ticks until the stop press, with false-start and timeout detection.
// Ports: CLK, RST_N (sync active-low), tick_in (1 kHz square wave, rising edge = 1 ms),
//        start/stop (debounced levels), led (stimulus), ms_count (binary ms),
//        bcd (ms_count as 4 BCD digits), done, false_start, timeout.
module reaction_measure
    import reaction_pkg::*;
#(
    parameter int unsigned    MAX_MS     = 9999,
    parameter int unsigned    DELAY_MIN  = 1000,
    parameter int unsigned    DELAY_BITS = 11,
    parameter int unsigned    RANDOM     = 1,
    parameter logic [15:0]    LFSR_SEED  = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    output logic             led,
    output logic [MS_W-1:0]  ms_count,
    output logic [BCD_W-1:0] bcd,
    output logic             done,
    output logic             false_start,
    output logic             timeout
);

    localparam int unsigned         WAIT_W  = $clog2(DELAY_MIN + (2 ** DELAY_BITS) + 1);
    localparam logic [MS_W-1:0]     MS_LAST = MS_W'(MAX_MS - 1);
    localparam logic [WAIT_W-1:0]   WAIT_MIN = WAIT_W'(DELAY_MIN);

    state_t              state_q, state_d;
    logic                tick_q, start_q, stop_q;
    logic                rise_tick, rise_start, rise_stop;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [WAIT_W-1:0]   wait_q, wait_d, wait_load;
    logic [MS_W-1:0]     ms_d;
    logic                led_d, done_d, fs_d, to_d;
    logic                bcd_clr, bcd_inc;

    assign rise_tick  = tick_in & ~tick_q;
    assign rise_start = start & ~start_q;
    assign rise_stop  = stop & ~stop_q;

    // Wait length sampled from the LFSR value present on the start edge
    assign wait_load = WAIT_MIN +
                       ((RANDOM != 0) ? WAIT_W'(lfsr_q[DELAY_BITS-1:0]) : WAIT_W'(0));

    // State, history and output registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            tick_q      <= 1'b1;
            start_q     <= 1'b1;
            stop_q      <= 1'b1;
            lfsr_q      <= LFSR_SEED;
            wait_q      <= '0;
            ms_count    <= '0;
            led         <= 1'b0;
            done        <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_in;
            start_q     <= start;
            stop_q      <= stop;
            lfsr_q      <= lfsr_next(lfsr_q);
            wait_q      <= wait_d;
            ms_count    <= ms_d;
            led         <= led_d;
            done        <= done_d;
            false_start <= fs_d;
            timeout     <= to_d;
        end
    end

    // Next state and next output values; stop always takes priority over a tick
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ms_d    = ms_count;
        led_d   = led;
        done_d  = done;
        fs_d    = false_start;
        to_d    = timeout;
        bcd_clr = 1'b0;
        bcd_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise_start) begin
                    state_d = ST_DELAY;
                    wait_d  = wait_load;
                end
            end
            ST_DELAY: begin
                if (rise_stop) begin
                    state_d = ST_FAULT;
                    fs_d    = 1'b1;
                end else if (rise_tick) begin
                    if (wait_q <= WAIT_W'(1)) begin
                        state_d = ST_MEASURE;
                        led_d   = 1'b1;
                        ms_d    = '0;
                        bcd_clr = 1'b1;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
            end
            ST_MEASURE: begin
                if (rise_stop) begin
                    state_d = ST_RESULT;
                    done_d  = 1'b1;
                    led_d   = 1'b0;
                end else if (rise_tick) begin
                    ms_d    = ms_count + MS_W'(1);
                    bcd_inc = 1'b1;
                    if (ms_count == MS_LAST) begin
                        state_d = ST_RESULT;
                        done_d  = 1'b1;
                        to_d    = 1'b1;
                        led_d   = 1'b0;
                    end
                end
            end
            ST_RESULT, ST_FAULT: begin
                if (rise_start) begin
                    state_d = ST_DELAY;
                    wait_d  = wait_load;
                    done_d  = 1'b0;
                    fs_d    = 1'b0;
                    to_d    = 1'b0;
                    ms_d    = '0;
                    bcd_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
            end
        endcase
    end

    bcd_counter u_bcd (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clear (bcd_clr),
        .inc   (bcd_inc),
        .bcd   (bcd)
    );

endmodule

// File: tb/tb_reaction_measure.sv
// Self-checking bench for reaction_measure: three instances (short fixed wait,
// short timeout, default random wait) checked against arithmetic expectations.
module tb_reaction_measure;

    logic CLK = 1'b0;
    logic RST_N;
    logic tick_in, start, stop, start_c, stop_c;

    logic        a_led, a_done, a_fs, a_to;
    logic [13:0] a_ms;
    logic [15:0] a_bcd;
    logic        t_led, t_done, t_fs, t_to;
    logic [13:0] t_ms;
    logic [15:0] t_bcd;
    logic        r_led, r_done, r_fs, r_to;
    logic [13:0] r_ms;
    logic [15:0] r_bcd;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;

    always #5 CLK = ~CLK;

    reaction_measure #(.MAX_MS(9999), .DELAY_MIN(5), .DELAY_BITS(11), .RANDOM(0)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .tick_in(tick_in), .start(start), .stop(stop),
        .led(a_led), .ms_count(a_ms), .bcd(a_bcd), .done(a_done),
        .false_start(a_fs), .timeout(a_to));

    reaction_measure #(.MAX_MS(12), .DELAY_MIN(5), .DELAY_BITS(11), .RANDOM(0)) u_to (
        .CLK(CLK), .RST_N(RST_N), .tick_in(tick_in), .start(start), .stop(stop),
        .led(t_led), .ms_count(t_ms), .bcd(t_bcd), .done(t_done),
        .false_start(t_fs), .timeout(t_to));

    reaction_measure u_rnd (
        .CLK(CLK), .RST_N(RST_N), .tick_in(tick_in), .start(start_c), .stop(stop_c),
        .led(r_led), .ms_count(r_ms), .bcd(r_bcd), .done(r_done),
        .false_start(r_fs), .timeout(r_to));

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, one shift per clock
    always @(posedge CLK) begin
        if (!RST_N) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [31:0] to_bcd(input int n);
        return 32'(((n / 1000) % 10) << 12 | ((n / 100) % 10) << 8 | ((n / 10) % 10) << 4 | (n % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input bit l, input bit d, input bit f, input bit t, input int ms);
        chk({tag, ".a.led"},  32'(a_led),  32'(l));
        chk({tag, ".a.done"}, 32'(a_done), 32'(d));
        chk({tag, ".a.fs"},   32'(a_fs),   32'(f));
        chk({tag, ".a.to"},   32'(a_to),   32'(t));
        chk({tag, ".a.ms"},   32'(a_ms),   32'(ms));
        chk({tag, ".a.bcd"},  32'(a_bcd),  to_bcd(ms));
    endtask

    task automatic chk_t(input string tag, input bit l, input bit d, input bit f, input bit t, input int ms);
        chk({tag, ".t.led"},  32'(t_led),  32'(l));
        chk({tag, ".t.done"}, 32'(t_done), 32'(d));
        chk({tag, ".t.fs"},   32'(t_fs),   32'(f));
        chk({tag, ".t.to"},   32'(t_to),   32'(t));
        chk({tag, ".t.ms"},   32'(t_ms),   32'(ms));
        chk({tag, ".t.bcd"},  32'(t_bcd),  to_bcd(ms));
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Each tick: two cycles high, two low; the rise is seen on the first edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1; cyc(); cyc();
            tick_in = 1'b0; cyc(); cyc();
        end
    endtask

    task automatic press_start();
        start = 1'b1; cyc(); cyc();
        start = 1'b0; cyc();
    endtask

    task automatic press_stop();
        stop = 1'b1; cyc(); cyc();
        stop = 1'b0; cyc();
    endtask

    // Stop rise and tick rise land on the same clock edge
    task automatic stop_with_tick();
        tick_in = 1'b1; stop = 1'b1; cyc(); cyc();
        tick_in = 1'b0; stop = 1'b0; cyc(); cyc();
    endtask

    initial begin
        int n, k, exp_ms, exp_w;
        bit co;

        // Reset with every input already high: no edges may be seen afterwards
        RST_N = 1'b0; tick_in = 1'b1; start = 1'b1; stop = 1'b1; start_c = 1'b1; stop_c = 1'b1;
        repeat (3) cyc();
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_a("rst_hold", 0, 0, 0, 0, 0);
            chk_t("rst_hold", 0, 0, 0, 0, 0);
        end
        tick_in = 1'b0; start = 1'b0; stop = 1'b0; start_c = 1'b0; stop_c = 1'b0;
        cyc();
        press_stop();
        tick(3);
        chk_a("idle_ignores", 0, 0, 0, 0, 0);

        // Basic run: LED on the 5th tick, start in DELAY ignored, timeout on the short instance
        press_start();
        tick(2);
        press_start();
        tick(2);
        chk_a("delay4", 0, 0, 0, 0, 0);
        tick(1);
        chk_a("led_on", 1, 0, 0, 0, 0);
        chk_t("led_on", 1, 0, 0, 0, 0);
        tick(11);
        chk_t("pre_to", 1, 0, 0, 0, 11);
        tick(1);
        chk_t("timeout", 0, 1, 0, 1, 12);
        chk_a("ms12", 1, 0, 0, 0, 12);
        tick(111);
        chk_a("ms123", 1, 0, 0, 0, 123);
        chk_t("to_sat", 0, 1, 0, 1, 12);
        press_stop();
        chk_a("result123", 0, 1, 0, 0, 123);
        tick(3);
        chk_a("result_hold", 0, 1, 0, 0, 123);

        // False start, then a restart that clears it; stop coincident with a tick at 40
        press_start();
        chk_a("restart_clr", 0, 0, 0, 0, 0);
        tick(2);
        press_stop();
        chk_a("false_start", 0, 0, 1, 0, 0);
        tick(6);
        chk_a("fault_hold", 0, 0, 1, 0, 0);
        press_start();
        chk_a("fault_clr", 0, 0, 0, 0, 0);
        tick(5);
        chk_a("rerun_led", 1, 0, 0, 0, 0);
        tick(40);
        stop_with_tick();
        chk_a("stop_tick40", 0, 1, 0, 0, 40);
        chk_t("stop_tick40", 0, 1, 0, 1, 12);

        // Stop coincident with the final wait tick: the false start wins
        press_start();
        tick(4);
        stop_with_tick();
        chk_a("stop_last_wait", 0, 0, 1, 0, 0);

        // BCD carry through every digit
        press_start();
        tick(5);
        tick(999);
        chk_a("bcd999", 1, 0, 0, 0, 999);
        tick(1);
        chk_a("bcd1000", 1, 0, 0, 0, 1000);
        press_stop();
        chk_a("result1000", 0, 1, 0, 0, 1000);

        // Randomised reaction times, stop either separate or coincident with a tick
        for (int r = 0; r < 6; r++) begin
            n  = int'($urandom_range(0, 300));
            co = 1'($urandom_range(0, 1));
            press_start();
            tick(5);
            tick(n);
            if (co) stop_with_tick();
            else    press_stop();
            exp_ms = (n >= 12) ? 12 : n;
            chk_a("rand_run", 0, 1, 0, 0, n);
            chk_t("rand_run", 0, 1, 0, n >= 12, exp_ms);
        end

        // Reset during MEASURE returns to idle at once and stays idle
        press_start();
        tick(5);
        tick(50);
        chk_a("pre_reset", 1, 0, 0, 0, 50);
        RST_N = 1'b0;
        cyc();
        chk_a("mid_reset", 0, 0, 0, 0, 0);
        chk_t("mid_reset", 0, 0, 0, 0, 0);
        RST_N = 1'b1;
        cyc();
        press_stop();
        tick(6);
        chk_a("post_reset_idle", 0, 0, 0, 0, 0);

        // Random wait on the default instance, predicted from the reference LFSR
        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(0, 40)) cyc();
            exp_w = 1000 + int'(m_lfsr & 16'h07FF);
            start_c = 1'b1; cyc();
            start_c = 1'b0; cyc();
            k = 0;
            while (r_led !== 1'b1 && k < 3100) begin
                tick(1);
                k++;
            end
            chk("rnd_wait", 32'(k), 32'(exp_w));
            chk("rnd_range", 32'(k >= 1000 && k <= 3047), 32'd1);
            n = int'($urandom_range(0, 100));
            tick(n);
            stop_c = 1'b1; cyc();
            stop_c = 1'b0; cyc();
            chk("rnd_ms", 32'(r_ms), 32'(n));
            chk("rnd_bcd", 32'(r_bcd), to_bcd(n));
            chk("rnd_done", 32'(r_done), 32'd1);
            chk("rnd_fs", 32'(r_fs), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_measure.md
Name: reaction_measure

Overview:
Measurement core of the reaction timer. It consumes the 1 kHz divided clock produced by the clock divider and turns it into a millisecond time base. It runs the game sequence: start press, then a pseudo-random wait, then the stimulus LED turns on, then it measures the ms until the stop press. The result is presented as a binary count and as 4-digit BCD for the seven-segment driver.

Parameters:
MAX_MS, 9999, saturation/timeout value in ms; must be ≤ 9999.
DELAY_MIN, 1000, minimum wait before the LED turns on, in ms.
DELAY_BITS, 11, width of the random add-on to the wait (0..2^DELAY_BITS-1 ms); must be ≥ 1.
RANDOM, 1, 1 = add an LFSR-derived random wait; 0 = wait is exactly DELAY_MIN.
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
CLK  in  1  system clock
RST_N  in  1  synchronous active-low reset
tick_in  in  1  divided clock (1 kHz square wave, CLK domain); each rising edge = 1 ms
start  in  1  debounced start button, level
stop  in  1  debounced reaction button, level
led  out  1  stimulus LED
ms_count  out  14  measured/elapsing reaction time, binary
bcd  out  16  ms_count as 4 BCD digits, [15:12] = thousands
done  out  1  valid result held
false_start  out  1  stop pressed before LED on
timeout  out  1  MAX_MS reached without stop

Behaviour:
- Reset (RST_N=0 at posedge CLK):
  - state IDLE; all outputs 0; LFSR = LFSR_SEED.
  - Edge-detect history registers for tick_in, start and stop reset to 1, so an input that is already high at reset release is not seen as an edge.
- Edge detection: rise_x = x & ~x_q, with x_q the previous-cycle sample. The FSM acts on the same posedge where the rise is seen, so outputs change 1 CLK after the input is sampled high.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every CLK in every state.
- Wait load: on the start rise, wait = DELAY_MIN + (RANDOM ? lfsr[DELAY_BITS-1:0] : 0). The counter is wide enough for DELAY_MIN + 2^DELAY_BITS.
- IDLE:
  - rise_start → DELAY; load wait.
  - stop ignored.
- DELAY:
  - Each tick rise decrements wait.
  - Tick rise when wait == 1 → MEASURE; led=1; ms_count=0; bcd=0.
  - rise_stop → FAULT; false_start=1; led stays 0. If rise_stop and a tick rise occur in the same cycle, stop wins.
  - rise_start is ignored.
- MEASURE:
  - Each tick rise increments ms_count and bcd together. BCD carries ripple within the same cycle; bcd must always equal ms_count in decimal.
  - rise_stop → RESULT; done=1; led=0; count frozen. If rise_stop and a tick rise occur in the same cycle, stop wins and that tick is not counted.
  - Tick rise when ms_count == MAX_MS-1 → ms_count=MAX_MS, then RESULT with done=1, timeout=1, led=0. ms_count never exceeds MAX_MS.
- RESULT / FAULT:
  - All outputs are held.
  - rise_start → clear done, false_start, timeout, ms_count and bcd; load a new wait; → DELAY.
  - stop and tick are ignored.
- Reset mid-operation: returns to IDLE immediately, whatever the state, with the reset values listed above.
- Undefined state encodings → IDLE.

Decomposition:
- Shared package reaction_pkg:
  - state encoding (IDLE, DELAY, MEASURE, RESULT, FAULT);
  - BCD_DIGITS = 4;
  - MS_W = 14;
  - LFSR tap constant.
- Sub-module bcd_counter: synchronous clear, increment enable, 4 cascaded decimal digits with ripple carry. It is reused later by the scoreboard/best-time logic.
- The LFSR stays inline.

Test Plan:
- Reset with start/stop/tick_in all high → no edges are seen; state IDLE; all outputs 0 for 20 cycles after RST_N=1.
- RANDOM=0, DELAY_MIN=5: start pulse, then tick edges → led=1 on the 5th tick rise. Stop after 123 tick rises → done=1, ms_count=123, bcd=16'h0123, led=0.
- RANDOM=0, DELAY_MIN=5: stop pulse after 2 ticks → false_start=1, led never 1, done=0. A start pulse then clears false_start and the sequence reruns.
- MAX_MS=12: no stop → on the 12th tick rise after the LED turns on, ms_count=12, timeout=1, done=1, led=0. Further ticks leave ms_count at 12.
- BCD carry: measure 999 then 1000 ticks → bcd=16'h0999 then 16'h1000. Stop and a tick rise in the same cycle at ms_count=40 → final ms_count=40.
- RST_N asserted in MEASURE at ms_count=50 → next cycle state IDLE, led=0, ms_count=0. RANDOM=1 with the default seed → wait within 1000..3047 ms and matches a model LFSR.
